// File: rtl/int_ctrl.sv
// Interrupt controller owning the IF/IE registers: per-source edge/level capture,
// fixed lowest-index-first priority, vector address generation and bus readback.
module int_ctrl #(
    parameter int unsigned NUM_SRC     = 5,
    parameter logic [7:0]  EDGE_MASK   = 8'h1F,
    parameter logic [15:0] IF_ADDR     = 16'hFF0F,
    parameter logic [15:0] IE_ADDR     = 16'hFFFF,
    parameter logic        UNUSED_FILL = 1'b1,
    parameter logic [15:0] VEC_BASE    = 16'h0040,
    parameter logic [15:0] VEC_STRIDE  = 16'h0008
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        a,
    input  logic [7:0]         din,
    input  logic               wr,
    input  logic               rd,
    output logic [7:0]         dout,
    output logic               dout_en,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               int_ack,
    output logic               int_req,
    output logic [2:0]         int_idx,
    output logic [15:0]        int_addr,
    output logic [NUM_SRC-1:0] if_q,
    output logic [7:0]         ie_q
);

    localparam logic [NUM_SRC-1:0] EDGE_SEL = EDGE_MASK[NUM_SRC-1:0];

    logic [NUM_SRC-1:0] src_q;
    logic               wr_q;
    logic [NUM_SRC-1:0] if_d;
    logic [7:0]         ie_d;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] set;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] base;
    logic               wr_stb;
    logic               hit_if;
    logic               hit_ie;
    logic [7:0]         rd_if;

    // Request, priority encode and vector address, all from registered state
    always_comb begin
        pend    = if_q & ie_q[NUM_SRC-1:0];
        int_req = |pend;
        int_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) int_idx = 3'(i);
        end
        int_addr = VEC_BASE + 16'(int_idx) * VEC_STRIDE;
    end

    // Next state: ack clear uses pre-write IF selection, hardware set wins last
    always_comb begin
        wr_stb = wr & ~wr_q;
        set    = (irq_src & ~src_q & EDGE_SEL) | (irq_src & ~EDGE_SEL);
        clr    = '0;
        if (int_ack && int_req) clr = NUM_SRC'(1) << int_idx;
        base   = if_q;
        if (wr_stb && a == IF_ADDR) base = din[NUM_SRC-1:0];
        if_d   = (base & ~clr) | set;
        ie_d   = ie_q;
        if (wr_stb && a == IE_ADDR) ie_d = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_q  <= '0;
            ie_q  <= '0;
            src_q <= '0;
            wr_q  <= 1'b0;
        end else begin
            if_q  <= if_d;
            ie_q  <= ie_d;
            src_q <= irq_src;
            wr_q  <= wr;
        end
    end

    // Combinational read path for the top-level read mux
    always_comb begin
        rd_if              = {8{UNUSED_FILL}};
        rd_if[NUM_SRC-1:0] = if_q;
        hit_if             = (a == IF_ADDR);
        hit_ie             = (a == IE_ADDR);
        dout_en            = rd & ~wr & (hit_if | hit_ie);
        dout               = '0;
        if (dout_en) dout = hit_if ? rd_if : ie_q;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised interrupt controller that owns the IF (interrupt flag) and IE (interrupt enable) registers on the system bus. It replaces the fixed 5-bit IF/IE glue in the top level. It latches interrupt events from N peripheral sources, each source configurable for edge or level capture. It presents a prioritised request, index and vector address to the CPU, and clears the serviced flag on a CPU acknowledge. Bus reads return data through `dout`/`dout_en` for the top-level read mux.

## Interface
Parameters:
- `NUM_SRC`, 5: number of interrupt sources, 1..8; bit 0 has the highest priority.
- `EDGE_MASK`, 8'h1F: per source, 1 = rising-edge capture, 0 = level capture. Only bits [NUM_SRC-1:0] are used.
- `IF_ADDR`, 16'hFF0F: bus address of IF.
- `IE_ADDR`, 16'hFFFF: bus address of IE.
- `UNUSED_FILL`, 1'b1: read value of IF bits [7:NUM_SRC].
- `VEC_BASE`, 16'h0040: vector address of source 0.
- `VEC_STRIDE`, 16'h0008: vector spacing per source index.

Ports:
- `clk` in 1: system clock (4.19 MHz domain). Only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `a` in 16: bus address.
- `din` in 8: bus write data.
- `wr` in 1: bus write enable, level, may be held for several cycles.
- `rd` in 1: bus read enable, level.
- `dout` in/out: out 8: read data.
- `dout_en` out 1: `dout` valid for this address; high iff `rd & ~wr & (a==IF_ADDR | a==IE_ADDR)`.
- `irq_src` in NUM_SRC: raw source requests, synchronous to `clk`.
- `int_ack` in 1: one-cycle pulse from the CPU when it dispatches the current request.
- `int_req` out 1: `|(IF & IE[NUM_SRC-1:0])`.
- `int_idx` out 3: index of the lowest-numbered pending and enabled bit; 0 when none is pending.
- `int_addr` out 16: `VEC_BASE + int_idx*VEC_STRIDE`, 16-bit wrap.
- `if_q` out NUM_SRC: IF contents, for debug.
- `ie_q` out 8: IE contents, for debug.

## Operation
- **Registers.** IF is NUM_SRC bits. IE is a full 8 bits, and all 8 are readable and writable. Only IE[NUM_SRC-1:0] gate requests.
- **Edge capture.** `src_q` is a registered copy of `irq_src`. For an edge source, the set term is `irq_src & ~src_q`. For a level source, the set term is `irq_src`, applied every cycle it is high.
- **Write strobe.** `wr_q` is a registered copy of `wr`. A bus write takes effect only in the cycle where `wr & ~wr_q`, i.e. the first cycle of the `wr` assertion. Holding `wr` high does not repeat the load, so hardware-set flags raised during a held write survive.
- **IF next-state.** Evaluated in this order:
  - `base` = write-strobe & a==IF_ADDR ? din[NUM_SRC-1:0] : IF.
  - `clr` = int_ack & int_req ? one-hot(int_idx) : 0, computed from the pre-update IF.
  - IF_next = (base & ~clr) | set.
  - Hardware set wins over both software clear and ack. The ack clears the bit selected before any same-cycle write.
- **IE next-state.** IE_next = write-strobe & a==IE_ADDR ? din : IE.
- **Ack with no request.** `int_ack` while `int_req`=0 is ignored.
- **Read data.**
  - At IF_ADDR: `{UNUSED_FILL bits [7:NUM_SRC], IF}`.
  - At IE_ADDR: IE.
  - Otherwise `dout` = 8'h00 and `dout_en` = 0.
- **Priority.** Fixed, lowest index first. No nesting or masking logic lives here; IME stays in the CPU.

## Timing
- **Reset.** While `rst_n`=0 and after release:
  - IF=0, IE=0, src_q=0, wr_q=0.
  - int_req=0, int_idx=0, int_addr=VEC_BASE, dout=0, dout_en=0.
- **Source high at reset release.** An edge source sees a rising edge on the first clock after release, because src_q resets to 0.
- **Capture latency.** A source high at clock edge N sets IF at edge N. `int_req`, `int_idx` and `int_addr` reflect it after edge N, one cycle of latency. All request outputs are combinational from registers.
- **Write latency.** A write strobe at edge N updates the register at edge N. A read at N+1 returns the new value.
- **Ack latency.** An ack sampled at edge N clears the bit at edge N. If another bit is pending, `int_req` stays high and `int_idx` moves to it at N+1.
- **Read path.** Combinational: `dout`/`dout_en` follow `a`/`rd` in the same cycle.
- **Reset mid-operation.** Asynchronous clear of all state. No pending event survives reset.

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-cycle with IF=5'h1F and IE=8'hFF -> IF=0, IE=0, int_req=0, int_addr=16'h0040 immediately, without waiting for a clock edge.
- **Edge source and vectoring.**
  - Write IE=8'h04. Pulse `irq_src[2]` for 3 cycles -> IF=5'h04 set once, int_req=1, int_idx=2, int_addr=16'h0050.
  - Pulse `int_ack` -> IF=0 and int_req=0 next cycle.
- **Priority and ack order.**
  - IE=8'h1F. Raise sources 1 and 3 in the same cycle -> int_idx=1, int_addr=16'h0048.
  - Ack -> int_idx=3, int_addr=16'h0058.
  - Ack -> int_req=0.
- **Held write and collisions.**
  - Hold `wr` for 4 cycles writing IF=5'h00, with an `irq_src[0]` edge in cycle 2 -> IF[0]=1 at the end.
  - Same-cycle write of IF=0, ack, and `irq_src[1]` edge -> IF=5'h02.
- **Readback and fill.**
  - NUM_SRC=5, UNUSED_FILL=1, IF=5'h05 -> read IF_ADDR gives 8'hE5 with dout_en=1.
  - Read IE after writing 8'hA3 -> 8'hA3.
  - Read at 16'hFF10 -> dout_en=0.
- **Level mode and parametrisation.**
  - NUM_SRC=8, EDGE_MASK=8'h00. Hold `irq_src[7]`=1, ack repeatedly -> IF[7] re-sets every cycle and int_req stays 1.
  - IE=8'h80 -> int_addr=16'h0078.
